// File: rtl/rr_lock_arbiter.sv
// 4-input round-robin arbiter that holds its grant for BEATS transfers so packets never interleave.
// Optional stall counter output io_stall_cycles when RR_LOCK_ARBITER_PERF_EN is defined.
module rr_lock_arbiter #(
  parameter int WIDTH = 8,
  parameter int BEATS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_0_valid,
  input  logic [WIDTH-1:0] io_in_0_bits,
  output logic             io_in_0_ready,
  input  logic             io_in_1_valid,
  input  logic [WIDTH-1:0] io_in_1_bits,
  output logic             io_in_1_ready,
  input  logic             io_in_2_valid,
  input  logic [WIDTH-1:0] io_in_2_bits,
  output logic             io_in_2_ready,
  input  logic             io_in_3_valid,
  input  logic [WIDTH-1:0] io_in_3_bits,
  output logic             io_in_3_ready,
  input  logic             io_out_ready,
  output logic             io_out_valid,
  output logic [WIDTH-1:0] io_out_bits,
  output logic [1:0]       io_chosen,
  output logic             io_fire,
  output logic             io_locked
`ifdef RR_LOCK_ARBITER_PERF_EN
  ,
  output logic [15:0]      io_stall_cycles
`endif
);

  localparam int CW = $clog2(BEATS) + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t         r_state, w_state_next;
  logic [1:0]     r_last, w_last_next;
  logic [1:0]     r_lock_idx, w_lock_idx_next;
  logic [CW-1:0]  r_beat_cnt, w_beat_cnt_next;

  logic [3:0]       w_valid;
  logic [WIDTH-1:0] w_bits [4];
  logic [3:0]       w_ready;
  logic [1:0]       w_scan_idx;
  logic [1:0]       w_cand;
  logic             w_scan_hit;
  logic [1:0]       w_chosen;
  logic             w_fire;

  assign w_valid = {io_in_3_valid, io_in_2_valid, io_in_1_valid, io_in_0_valid};
  assign w_bits[0] = io_in_0_bits;
  assign w_bits[1] = io_in_1_bits;
  assign w_bits[2] = io_in_2_bits;
  assign w_bits[3] = io_in_3_bits;

  // Cyclic scan starting just after the previous packet's owner; falls back to last+1.
  always_comb begin
    w_scan_idx = r_last + 2'd1;
    w_scan_hit = 1'b0;
    w_cand     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_last + 2'(k);
      if (!w_scan_hit && w_valid[w_cand]) begin
        w_scan_idx = w_cand;
        w_scan_hit = 1'b1;
      end
    end
  end

  assign w_chosen     = (r_state == LOCKED) ? r_lock_idx : w_scan_idx;
  assign w_fire       = w_valid[w_chosen] & io_out_ready;
  assign io_chosen    = w_chosen;
  assign io_out_valid = w_valid[w_chosen];
  assign io_out_bits  = w_bits[w_chosen];
  assign io_fire      = w_fire;
  assign io_locked    = (r_state == LOCKED);

  // Ready is granted to the selected slot only and deliberately ignores its valid.
  for (genvar gi = 0; gi < 4; gi++) begin : g_ready
    assign w_ready[gi] = io_out_ready & (w_chosen == 2'(gi));
  end

  assign io_in_0_ready = w_ready[0];
  assign io_in_1_ready = w_ready[1];
  assign io_in_2_ready = w_ready[2];
  assign io_in_3_ready = w_ready[3];

  always_comb begin
    w_state_next    = r_state;
    w_last_next     = r_last;
    w_lock_idx_next = r_lock_idx;
    w_beat_cnt_next = r_beat_cnt;
    if (w_fire) begin
      case (r_state)
        IDLE: begin
          if (BEATS == 1) begin
            w_last_next = w_chosen;
          end else begin
            w_lock_idx_next = w_chosen;
            w_beat_cnt_next = CW'(BEATS - 1);
            w_state_next    = LOCKED;
          end
        end
        LOCKED: begin
          if (r_beat_cnt > CW'(1)) begin
            w_beat_cnt_next = r_beat_cnt - CW'(1);
          end else begin
            w_last_next     = r_lock_idx;
            w_beat_cnt_next = '0;
            w_state_next    = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= 2'd3;
      r_lock_idx <= 2'd0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_last     <= w_last_next;
      r_lock_idx <= w_lock_idx_next;
      r_beat_cnt <= w_beat_cnt_next;
    end
  end

`ifdef RR_LOCK_ARBITER_PERF_EN
  logic [15:0] r_stall_cycles;

  // Saturating count of cycles where data is offered but the channel is back-pressured.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 16'd0;
    end else if (io_out_valid && !io_out_ready && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign io_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter: packet-level reference model checked every cycle plus directed literal checks.
module tb_rr_lock_arbiter;
  localparam int WIDTH = 8;
  localparam int BEATS = 4;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] vld;
  logic [WIDTH-1:0] bits_tbl [4];
  logic out_ready;
  logic [3:0] rdy;
  logic out_valid, fire, locked;
  logic [WIDTH-1:0] out_bits;
  logic [1:0] chosen;
`ifdef RR_LOCK_ARBITER_PERF_EN
  logic [15:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_pass = 0;
  bit check_en = 1'b0;

  // Model state: who owns the current packet and how many beats remain after the current one.
  int m_last, m_owner, m_left;

  rr_lock_arbiter #(.WIDTH(WIDTH), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .io_in_0_valid(vld[0]), .io_in_0_bits(bits_tbl[0]), .io_in_0_ready(rdy[0]),
    .io_in_1_valid(vld[1]), .io_in_1_bits(bits_tbl[1]), .io_in_1_ready(rdy[1]),
    .io_in_2_valid(vld[2]), .io_in_2_bits(bits_tbl[2]), .io_in_2_ready(rdy[2]),
    .io_in_3_valid(vld[3]), .io_in_3_bits(bits_tbl[3]), .io_in_3_ready(rdy[3]),
    .io_out_ready(out_ready), .io_out_valid(out_valid), .io_out_bits(out_bits),
    .io_chosen(chosen), .io_fire(fire), .io_locked(locked)
`ifdef RR_LOCK_ARBITER_PERF_EN
    , .io_stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // One compare process: predict from the model, compare, then advance the model.
  always @(negedge clk) begin
    int e_ch;
    bit e_vld, e_fire;
    if (m_left > 0) begin
      e_ch = m_owner;
    end else begin
      e_ch = (m_last + 1) % 4;
      for (int k = 4; k >= 1; k--)
        if (vld[(m_last + k) % 4]) e_ch = (m_last + k) % 4;
    end
    e_vld  = vld[e_ch];
    e_fire = e_vld && out_ready;
    if (check_en) begin
      chk("model_chosen", int'(chosen), e_ch);
      chk("model_out_valid", int'(out_valid), int'(e_vld));
      chk("model_out_bits", int'(out_bits), int'(bits_tbl[e_ch]));
      chk("model_fire", int'(fire), int'(e_fire));
      chk("model_locked", int'(locked), int'(m_left > 0));
      chk("model_ready", int'(rdy), out_ready ? (1 << e_ch) : 0);
    end
    if (reset) begin
      m_last = 3; m_left = 0; m_owner = 0;
    end else if (e_fire) begin
      if (m_left == 0) begin
        if (BEATS == 1) m_last = e_ch;
        else begin m_owner = e_ch; m_left = BEATS - 1; end
      end else begin
        m_left--;
        if (m_left == 0) m_last = m_owner;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic r);
    vld = v; out_ready = r; #1;
  endtask

  int exp_ch2 [8] = '{1, 1, 1, 1, 2, 2, 2, 2};
  int exp_lk2 [8] = '{0, 1, 1, 1, 0, 1, 1, 1};

  initial begin
    bits_tbl[0] = 8'hA0; bits_tbl[1] = 8'h11; bits_tbl[2] = 8'h22; bits_tbl[3] = 8'h33;
    m_last = 3; m_owner = 0; m_left = 0;
    reset = 1'b1; vld = 4'b0000; out_ready = 1'b0;
    step(); step();
    reset = 1'b0; check_en = 1'b1;

    // Reset state with nothing requesting.
    drive(4'b0000, 1'b0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_chosen", int'(chosen), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_readies", int'(rdy), 0);
    step();

    // Back-pressure: in1 offered but not accepted, so no lock is taken.
    drive(4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_chosen", int'(chosen), 1);
      chk("bp_fire", int'(fire), 0);
      chk("bp_locked", int'(locked), 0);
      chk("bp_ready", int'(rdy), 0);
      step();
    end

    // in1 and in2 packets back to back.
    drive(4'b0110, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("pkt_chosen", int'(chosen), exp_ch2[i]);
      chk("pkt_locked", int'(locked), exp_lk2[i]);
      chk("pkt_bits", int'(out_bits), (exp_ch2[i] == 1) ? 8'h11 : 8'h22);
      step();
      drive(4'b0110, 1'b1);
    end

    // All valid from reset: 0x4, 1x4, 2x4, 3x4.
    reset = 1'b1; step(); reset = 1'b0;
    drive(4'b1111, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("rr_chosen", int'(chosen), i / 4);
      chk("rr_fire", int'(fire), 1);
      step();
    end

    // Locked to in2, owner stalls for 3 cycles while in0 waits, then finishes.
    drive(4'b0100, 1'b1);
    chk("stall_first_chosen", int'(chosen), 2);
    step();
    drive(4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_out_valid", int'(out_valid), 0);
      chk("stall_in0_ready", int'(rdy[0]), 0);
      chk("stall_chosen", int'(chosen), 2);
      step();
      drive(4'b0001, 1'b1);
    end
    drive(4'b0101, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("resume_chosen", int'(chosen), 2);
      chk("resume_fire", int'(fire), 1);
      step();
      drive(4'b0101, 1'b1);
    end
    chk("after_pkt_chosen", int'(chosen), 0);
    chk("after_pkt_locked", int'(locked), 0);
    step();

    // Reset mid-packet of in3.
    reset = 1'b1; step(); reset = 1'b0;
    drive(4'b1000, 1'b1);
    chk("mid_first_chosen", int'(chosen), 3);
    step();
    drive(4'b1001, 1'b1);
    chk("mid_second_chosen", int'(chosen), 3);
    chk("mid_second_locked", int'(locked), 1);
    reset = 1'b1; step(); reset = 1'b0; #1;
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_chosen", int'(chosen), 0);
    chk("mid_rst_bits", int'(out_bits), 8'hA0);
    step();

    // Varied traffic checked only by the model.
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      step();
    end

`ifdef RR_LOCK_ARBITER_PERF_EN
    reset = 1'b1; step(); reset = 1'b0;
    drive(4'b0001, 1'b0);
    repeat (5) step();
    chk("perf_stall5", int'(stall_cycles), 5);
    repeat (70000) step();
    chk("perf_saturate", int'(stall_cycles), 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
